// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory bus between instruction fetch and the
// MEM stage, sequencing each transfer through IDLE/FETCH/DATA/RESP.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [AW-1:0]     if_addr,
    input  logic              if_flush,
    output logic [DW-1:0]     if_rdata,
    output logic              if_valid,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [AW-1:0]     mem_addr,
    input  logic [DW-1:0]     mem_wdata,
    input  logic [DW/8-1:0]   mem_be,
    output logic [DW-1:0]     mem_rdata,
    output logic              mem_done,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              bus_req,
    output logic              bus_we,
    output logic [AW-1:0]     bus_addr,
    output logic [DW-1:0]     bus_wdata,
    output logic [DW/8-1:0]   bus_be,
    input  logic              bus_ack,
    input  logic [DW-1:0]     bus_rdata,
    output logic              bus_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]      state_q, state_d;
    logic            bus_req_q, bus_req_d;
    logic            bus_we_q, bus_we_d;
    logic [AW-1:0]   bus_addr_q, bus_addr_d;
    logic [DW-1:0]   bus_wdata_q, bus_wdata_d;
    logic [DW/8-1:0] bus_be_q, bus_be_d;
    logic [DW-1:0]   if_rdata_q, if_rdata_d;
    logic [DW-1:0]   mem_rdata_q, mem_rdata_d;
    logic            drop_q, drop_d;
    logic            resp_fetch_q, resp_fetch_d;
    logic            bus_err_q, bus_err_d;
    logic [7:0]      tmo_q, tmo_d;
    logic            mem_any;

    assign mem_any = mem_rd | mem_wr;

    always_comb begin
        state_d      = state_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_be_d     = bus_be_q;
        if_rdata_d   = if_rdata_q;
        mem_rdata_d  = mem_rdata_q;
        drop_d       = drop_q;
        resp_fetch_d = resp_fetch_q;
        bus_err_d    = bus_err_q;
        tmo_d        = tmo_q;

        case (state_q)
            S_IDLE: begin
                // MEM is the older instruction, so it always wins the bus.
                if (mem_any) begin
                    state_d      = S_DATA;
                    bus_req_d    = 1'b1;
                    bus_we_d     = mem_wr;
                    bus_addr_d   = mem_addr;
                    bus_wdata_d  = mem_wdata;
                    bus_be_d     = mem_wr ? mem_be : '1;
                    resp_fetch_d = 1'b0;
                    drop_d       = 1'b0;
                    tmo_d        = '0;
                end else if (if_req && !if_flush) begin
                    state_d      = S_FETCH;
                    bus_req_d    = 1'b1;
                    bus_we_d     = 1'b0;
                    bus_addr_d   = if_addr;
                    bus_be_d     = '1;
                    resp_fetch_d = 1'b1;
                    drop_d       = 1'b0;
                    tmo_d        = '0;
                end
            end
            S_FETCH, S_DATA: begin
                if (state_q == S_FETCH && if_flush) begin
                    drop_d = 1'b1;
                end
                if (bus_ack) begin
                    bus_req_d = 1'b0;
                    state_d   = S_RESP;
                    if (state_q == S_FETCH) begin
                        if_rdata_d = bus_rdata;
                    end else if (!bus_we_q) begin
                        mem_rdata_d = bus_rdata;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    // Abort still walks through RESP so the waiting stage is released.
                    bus_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = S_RESP;
                    if (state_q == S_FETCH) begin
                        if_rdata_d = '0;
                    end else if (!bus_we_q) begin
                        mem_rdata_d = '0;
                    end
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            default: begin
                drop_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_be_q     <= '0;
            if_rdata_q   <= '0;
            mem_rdata_q  <= '0;
            drop_q       <= 1'b0;
            resp_fetch_q <= 1'b0;
            bus_err_q    <= 1'b0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_be_q     <= bus_be_d;
            if_rdata_q   <= if_rdata_d;
            mem_rdata_q  <= mem_rdata_d;
            drop_q       <= drop_d;
            resp_fetch_q <= resp_fetch_d;
            bus_err_q    <= bus_err_d;
            tmo_q        <= tmo_d;
        end
    end

    assign if_valid  = (state_q == S_RESP) && resp_fetch_q && !drop_q && !if_flush;
    assign mem_done  = (state_q == S_RESP) && !resp_fetch_q;
    assign stall_mem = mem_any & ~mem_done;
    assign stall_if  = (if_req & ~if_valid) | stall_mem;

    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_be    = bus_be_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected bus requests
// and responses, independent monitors compare what the DUT presents.
module tb_mem_port_arbiter;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          len;
    } bus_exp_t;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } rsp_exp_t;

    typedef struct {
        int          lat;
        logic [31:0] data;
    } slave_t;

    logic        clk, rst;
    logic        if_req, if_flush, if_valid;
    logic [31:0] if_addr, if_rdata;
    logic        mem_rd, mem_wr, mem_done;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        stall_if, stall_mem;
    logic        bus_req, bus_we, bus_ack, bus_err;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bus_exp_t busq[$];
    rsp_exp_t ifq[$];
    rsp_exp_t memq[$];
    slave_t   slvq[$];

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_valid(if_valid),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rdata(mem_rdata), .mem_done(mem_done),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_bus(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be, input int len, input int lat, input logic [31:0] rd);
        bus_exp_t b;
        slave_t   s;
        b.we = we; b.addr = a; b.wdata = wd; b.be = be; b.len = len;
        s.lat = lat; s.data = rd;
        busq.push_back(b);
        slvq.push_back(s);
    endtask

    task automatic exp_if(input logic [31:0] d, input int c);
        rsp_exp_t r;
        r.data = d; r.cyc = c;
        ifq.push_back(r);
    endtask

    task automatic exp_mem(input logic [31:0] d, input int c);
        rsp_exp_t r;
        r.data = d; r.cyc = c;
        memq.push_back(r);
    endtask

    // Bus slave: acks after the queued latency counted from the first bus_req cycle.
    initial begin
        slave_t cur;
        int     rcnt;
        logic   active;
        bus_ack   = 1'b0;
        bus_rdata = '0;
        active    = 1'b0;
        rcnt      = 0;
        cur.lat   = 0;
        cur.data  = '0;
        forever begin
            @(posedge clk);
            #2;
            if (bus_req) begin
                if (!active) begin
                    if (slvq.size() > 0) cur = slvq.pop_front();
                    else begin cur.lat = 0; cur.data = 32'hBAD0_BAD0; end
                    active = 1'b1;
                    rcnt   = 0;
                end
                bus_ack   = (rcnt == cur.lat);
                bus_rdata = (rcnt == cur.lat) ? cur.data : 32'h0;
                rcnt++;
            end else begin
                bus_ack = 1'b0;
                active  = 1'b0;
            end
        end
    end

    initial begin
        rsp_exp_t e;
        bus_exp_t b;
        logic     active;
        int       len;
        active = 1'b0;
        len    = 0;
        b.we = 0; b.addr = 0; b.wdata = 0; b.be = 0; b.len = 0;
        forever begin
            @(negedge clk);
            if (if_valid) begin
                if (ifq.size() == 0) chk("if_valid_unexpected", 32'd1, 32'd0);
                else begin
                    e = ifq.pop_front();
                    chk("if_rdata", if_rdata, e.data);
                    chk("if_valid_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (mem_done) begin
                if (memq.size() == 0) chk("mem_done_unexpected", 32'd1, 32'd0);
                else begin
                    e = memq.pop_front();
                    chk("mem_rdata", mem_rdata, e.data);
                    chk("mem_done_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (bus_req) begin
                if (!active) begin
                    active = 1'b1;
                    len    = 0;
                    if (busq.size() == 0) chk("bus_req_unexpected", 32'd1, 32'd0);
                    else begin
                        b = busq.pop_front();
                        chk("bus_we", 32'(bus_we), 32'(b.we));
                        chk("bus_addr", bus_addr, b.addr);
                        chk("bus_be", 32'(bus_be), 32'(b.be));
                        if (b.we) chk("bus_wdata", bus_wdata, b.wdata);
                    end
                end
                len++;
            end else if (active) begin
                active = 1'b0;
                chk("bus_req_len", 32'(len), 32'(b.len));
            end
        end
    end

    initial begin
        int g;
        rst = 1'b1; if_req = 0; if_addr = 0; if_flush = 0;
        mem_rd = 0; mem_wr = 0; mem_addr = 0; mem_wdata = 0; mem_be = 0;

        @(negedge clk);
        chk("rst_bus_req", 32'(bus_req), 0);
        chk("rst_bus_we", 32'(bus_we), 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_be", 32'(bus_be), 0);
        chk("rst_if_valid", 32'(if_valid), 0);
        chk("rst_mem_done", 32'(mem_done), 0);
        chk("rst_bus_err", 32'(bus_err), 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_mem_rdata", mem_rdata, 0);
        tick();
        rst = 1'b0;

        // Fetch, ack latency 0
        tick(); g = cyc;
        if_req = 1; if_addr = 32'h40;
        exp_bus(0, 32'h40, 0, 4'hF, 1, 0, 32'h2108_0001);
        exp_if(32'h2108_0001, g + 2);
        @(negedge clk); chk("stall_if_grant", 32'(stall_if), 1);
        tick(); @(negedge clk); chk("stall_if_bus", 32'(stall_if), 1);
        tick(); @(negedge clk); chk("stall_if_valid", 32'(stall_if), 0);
        tick(); if_req = 0;

        // Simultaneous IF + MEM read: MEM first, IF right after RESP
        tick(); g = cyc;
        if_req = 1; if_addr = 32'h44; mem_rd = 1; mem_addr = 32'h100;
        exp_bus(0, 32'h100, 0, 4'hF, 3, 2, 32'h1234_5678);
        exp_bus(0, 32'h44, 0, 4'hF, 1, 0, 32'h8C01_0004);
        exp_mem(32'h1234_5678, g + 4);
        exp_if(32'h8C01_0004, g + 7);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_mem_window", 32'(stall_mem), (k < 4) ? 32'd1 : 32'd0);
            tick();
        end
        mem_rd = 0;
        repeat (3) tick();
        if_req = 0;

        // Store: read data must be untouched
        tick(); g = cyc;
        mem_wr = 1; mem_addr = 32'h200; mem_wdata = 32'hDEAD_BEEF; mem_be = 4'b0011;
        exp_bus(1, 32'h200, 32'hDEAD_BEEF, 4'b0011, 2, 1, 32'hFFFF_FFFF);
        exp_mem(32'h1234_5678, g + 3);
        repeat (4) tick();
        mem_wr = 0;

        // rd and wr together behave as a write
        tick(); g = cyc;
        mem_rd = 1; mem_wr = 1; mem_addr = 32'h204; mem_wdata = 32'h0BAD_F00D; mem_be = 4'b1100;
        exp_bus(1, 32'h204, 32'h0BAD_F00D, 4'b1100, 1, 0, 32'hEEEE_EEEE);
        exp_mem(32'h1234_5678, g + 2);
        repeat (3) tick();
        mem_rd = 0; mem_wr = 0;

        // Ack on the last cycle before the timeout would fire
        tick(); g = cyc;
        mem_rd = 1; mem_addr = 32'h108;
        exp_bus(0, 32'h108, 0, 4'hF, 4, 3, 32'h0F0F_0F0F);
        exp_mem(32'h0F0F_0F0F, g + 5);
        repeat (6) tick();
        mem_rd = 0;
        @(negedge clk); chk("no_err_at_limit", 32'(bus_err), 0);

        // Flush mid-fetch, then redirected fetch
        tick(); g = cyc;
        if_req = 1; if_addr = 32'h60;
        exp_bus(0, 32'h60, 0, 4'hF, 2, 1, 32'h1111_1111);
        tick();
        if_flush = 1; if_addr = 32'h80;
        @(negedge clk); chk("stall_if_during_flush", 32'(stall_if), 1);
        tick();
        if_flush = 0;
        exp_bus(0, 32'h80, 0, 4'hF, 1, 0, 32'h2222_2222);
        exp_if(32'h2222_2222, g + 6);
        tick(); @(negedge clk); chk("flush_drop_valid", 32'(if_valid), 0);
        repeat (4) tick();
        if_req = 0;

        // Flush during RESP, then held flush blocks the IDLE grant
        tick(); g = cyc;
        if_req = 1; if_addr = 32'h90;
        exp_bus(0, 32'h90, 0, 4'hF, 1, 0, 32'h3333_3333);
        repeat (2) tick();
        if_flush = 1; if_addr = 32'h94;
        @(negedge clk); chk("resp_flush_valid", 32'(if_valid), 0);
        tick();
        tick();
        if_flush = 0;
        exp_bus(0, 32'h94, 0, 4'hF, 1, 0, 32'h4444_4444);
        exp_if(32'h4444_4444, g + 6);
        @(negedge clk); chk("idle_flush_blocks_grant", 32'(bus_req), 0);
        repeat (3) tick();
        if_req = 0;

        // Timeout on a load
        tick(); g = cyc;
        mem_rd = 1; mem_addr = 32'h300;
        exp_bus(0, 32'h300, 0, 4'hF, 4, 255, 32'h0);
        exp_mem(32'h0, g + 5);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("bus_err_timing", 32'(bus_err), (k >= 5) ? 32'd1 : 32'd0);
            tick();
        end
        mem_rd = 0;

        // Good load afterwards; error stays sticky
        tick(); g = cyc;
        mem_rd = 1; mem_addr = 32'h104;
        exp_bus(0, 32'h104, 0, 4'hF, 1, 0, 32'h55AA_55AA);
        exp_mem(32'h55AA_55AA, g + 2);
        repeat (3) tick();
        mem_rd = 0;
        @(negedge clk); chk("bus_err_sticky", 32'(bus_err), 1);

        // Asynchronous reset mid-DATA
        tick(); g = cyc;
        mem_rd = 1; mem_addr = 32'h10C;
        exp_bus(0, 32'h10C, 0, 4'hF, 1, 255, 32'h0);
        repeat (2) tick();
        chk("pre_rst_bus_req", 32'(bus_req), 1);
        rst = 1;
        #1;
        chk("async_rst_bus_req", 32'(bus_req), 0);
        chk("async_rst_mem_done", 32'(mem_done), 0);
        chk("async_rst_bus_err", 32'(bus_err), 0);
        tick();
        rst = 0; mem_addr = 32'h110; g = cyc;
        exp_bus(0, 32'h110, 0, 4'hF, 1, 0, 32'h7777_0000);
        exp_mem(32'h7777_0000, g + 2);
        repeat (3) tick();
        mem_rd = 0;

        repeat (4) tick();
        chk("if_queue_drained", 32'(ifq.size()), 0);
        chk("mem_queue_drained", 32'(memq.size()), 0);
        chk("bus_queue_drained", 32'(busq.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
